// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings for the buffered UART transmitter.
// Parity and stop-bit codes match the register-block field values.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: write port of the TX FIFO.
// The register block is master; the transmitter is slave.
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          wr_valid;
    logic [DATA_W-1:0]             wr_data;
    logic                          wr_ready;
    logic                          flush;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output wr_valid, wr_data, flush,
        input  wr_ready, fifo_level
    );

    modport slave (
        input  wr_valid, wr_data, flush,
        output wr_ready, fifo_level
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with level count and flush.
// Flush clears pointers and drops any same-cycle push.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_uart,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == FULL_LVL);
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign push_ok    = push_i && !full_o && !flush_i;
    assign pop_ok     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rptr_q];

    always_ff @(posedge clk_uart) begin
        if (push_ok) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with baud divider,
// run-time frame format and back-to-back frame streaming.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  clk_uart,
    input  logic                  rst_n,
    input  logic [BAUD_DIV_W-1:0] baud_div,
    input  logic [3:0]            data_bits,
    input  logic [2:0]            parity_mode,
    input  logic [1:0]            stop_bits,
    uart_tx_fifo_if.slave         wr,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int CW = BAUD_DIV_W + 1;
    localparam logic [3:0] MAX_BITS = DATA_W[3:0];

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]     sh_q, sh_d;
    logic [3:0]            bit_q, bit_d;
    logic [3:0]            nbits_q, nbits_d;
    logic                  par_q, par_d;
    logic [2:0]            pmode_q, pmode_d;
    logic [1:0]            stop_q, stop_d;
    logic [BAUD_DIV_W-1:0] div_q, div_d;
    logic                  tx_out_q, tx_out_d;
    logic                  tx_done_q, tx_done_d;

    logic                  fifo_empty, fifo_full;
    logic                  pop, load;
    logic [DATA_W-1:0]     head;
    logic [CW-1:0]         bit_len, period, stop_len;
    logic                  bit_end;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_uart    (clk_uart),
        .rst_n       (rst_n),
        .push_i      (wr.wr_valid),
        .push_data_i (wr.wr_data),
        .pop_i       (pop),
        .pop_data_o  (head),
        .flush_i     (wr.flush),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (wr.fifo_level)
    );

    assign wr.wr_ready = !fifo_full;

    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < 4'd5)     return 4'd5;
        if (b > MAX_BITS) return MAX_BITS;
        return b;
    endfunction

    // Counters hold "clocks remaining minus one" for the current slot
    assign bit_len = {1'b0, div_q};
    assign period  = bit_len + CW'(1);
    assign bit_end = (cnt_q == '0);

    always_comb begin
        unique case (stop_q)
            STOP_1:   stop_len = bit_len;
            STOP_1P5: stop_len = period + (period >> 1) - CW'(1);
            default:  stop_len = {div_q, 1'b1};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        par_d     = par_q;
        nbits_d   = nbits_q;
        pmode_d   = pmode_q;
        stop_d    = stop_q;
        div_d     = div_q;
        tx_done_d = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;

        unique case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = bit_len;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    sh_d  = sh_q >> 1;
                    par_d = par_q ^ sh_q[0];
                    bit_d = bit_q + 4'd1;
                    cnt_d = bit_len;
                    if (bit_q == nbits_q - 4'd1) begin
                        if (pmode_q == PAR_NONE) begin
                            state_d = ST_STOP;
                            cnt_d   = stop_len;
                        end else begin
                            state_d = ST_PARITY;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    cnt_d   = stop_len;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    tx_done_d = 1'b1;
                    load      = !fifo_empty;
                    if (fifo_empty) state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame format is frozen at pop time
        if (load) begin
            pop     = 1'b1;
            state_d = ST_START;
            sh_d    = head;
            bit_d   = '0;
            par_d   = 1'b0;
            nbits_d = clamp_bits(data_bits);
            pmode_d = (parity_mode > PAR_SPACE) ? PAR_NONE : parity_mode;
            stop_d  = stop_bits;
            div_d   = baud_div;
            cnt_d   = {1'b0, baud_div};
        end
    end

    always_comb begin
        tx_out_d = 1'b1;
        unique case (state_q)
            ST_START: tx_out_d = 1'b0;
            ST_DATA:  tx_out_d = sh_q[0];
            ST_PARITY: begin
                case (pmode_q)
                    PAR_EVEN: tx_out_d = par_q;
                    PAR_ODD:  tx_out_d = ~par_q;
                    PAR_MARK: tx_out_d = 1'b1;
                    default:  tx_out_d = 1'b0;
                endcase
            end
            default: tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            nbits_q   <= '0;
            pmode_q   <= PAR_NONE;
            stop_q    <= STOP_1;
            div_q     <= '0;
            tx_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            nbits_q   <= nbits_d;
            pmode_q   <= pmode_d;
            stop_q    <= stop_d;
            div_q     <= div_d;
            tx_out_q  <= tx_out_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign tx_out  = tx_out_q | ~rst_n;
    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = tx_done_q;
endmodule
